// File: rtl/snn_mem_pkg.sv
// Shared types and constants for the synapse weight memory: FSM state
// encodings, AXI response codes and byte-address to word-index conversion.
package snn_mem_pkg;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_COMMIT = 2'd1,
    W_RESP   = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_MEM  = 2'd1,
    R_RESP = 2'd2
  } r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned WORD_SHIFT = 2;

  function automatic logic [29:0] word_index(input logic [31:0] addr);
    return addr[31:WORD_SHIFT];
  endfunction

endpackage

// File: rtl/synapse_ram.sv
// Simple dual-port weight storage: one byte-enabled write port and one
// registered read port (read-before-write), written to map onto block RAM.
module synapse_ram #(
  parameter int DEPTH  = 72895,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [WIDTH/8-1:0]    wbe,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata_r;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) begin
          mem_r[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // A same-address write in the same cycle is not visible until the next read.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/synapse_weight_mem.sv
// Synapse weight memory: AXI4-Lite slave for host access plus a single-cycle
// core read port, sharing one RAM read port with bounded AXI starvation.
module synapse_weight_mem
  import snn_mem_pkg::*;
#(
  parameter int NUM_SYNAPSES = 72895,
  parameter int WEIGHT_W     = 16,
  parameter int SIGN_EXT     = 0,
  parameter int STARVE_LIM   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [31:0]                     s_axi_awaddr,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [31:0]                     s_axi_wdata,
  input  logic [3:0]                      s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [31:0]                     s_axi_araddr,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [31:0]                     s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  input  logic                            core_req,
  input  logic [$clog2(NUM_SYNAPSES)-1:0] core_addr,
  output logic                            core_gnt,
  output logic                            core_valid,
  output logic [WEIGHT_W-1:0]             core_weight
);

  localparam int IDX_W = $clog2(NUM_SYNAPSES);
  localparam int NB    = WEIGHT_W / 8;
  localparam int CNT_W = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
  localparam logic [29:0]      NUM_IDX = 30'(NUM_SYNAPSES);
  localparam logic [CNT_W-1:0] LIM_C   = CNT_W'(STARVE_LIM);

  function automatic logic [31:0] extend_weight(input logic [WEIGHT_W-1:0] w);
    logic [31:0] ext;
    ext = {32{(SIGN_EXT != 0) && w[WEIGHT_W-1]}};
    ext[WEIGHT_W-1:0] = w;
    return ext;
  endfunction

  w_state_e w_state_r, w_state_s;
  r_state_e r_state_r, r_state_s;

  logic              aw_held_r, w_held_r;
  logic [29:0]       aw_idx_r;
  logic [31:0]       w_data_r;
  logic [3:0]        w_strb_r;
  logic [1:0]        bresp_r;
  logic [29:0]       ar_idx_r;
  logic [CNT_W-1:0]  loss_cnt_r;
  logic [1:0]        rresp_r;
  logic              rd_oor_r, rd_first_r;
  logic [31:0]       rd_hold_r, rd_now_s;
  logic              core_valid_r, core_oor_r;

  logic                aw_fire_s, w_fire_s, aw_in_range_s, ar_in_range_s, core_in_range_s;
  logic                axi_use_s, ram_we_s, ram_re_s;
  logic [IDX_W-1:0]    ram_raddr_s;
  logic [WEIGHT_W-1:0] ram_rdata_s;
  logic                unused_s;

  assign aw_fire_s       = s_axi_awvalid && s_axi_awready;
  assign w_fire_s        = s_axi_wvalid && s_axi_wready;
  assign aw_in_range_s   = aw_idx_r < NUM_IDX;
  assign ar_in_range_s   = ar_idx_r < NUM_IDX;
  assign core_in_range_s = 30'(core_addr) < NUM_IDX;
  assign unused_s        = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], w_data_r, w_strb_r};

  // ---------------- write channel ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_r <= W_IDLE;
    end else begin
      w_state_r <= w_state_s;
    end
  end

  always_comb begin
    w_state_s = w_state_r;
    case (w_state_r)
      W_IDLE: begin
        if (aw_held_r && w_held_r) w_state_s = W_COMMIT;
        else                       w_state_s = W_IDLE;
      end
      W_COMMIT: w_state_s = W_RESP;
      W_RESP: begin
        if (s_axi_bready) w_state_s = W_IDLE;
        else              w_state_s = W_RESP;
      end
      default: w_state_s = W_IDLE;
    endcase
  end

  // A commit coinciding with reset is dropped so memory stays untouched.
  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    ram_we_s      = 1'b0;
    case (w_state_r)
      W_IDLE: begin
        s_axi_awready = !aw_held_r;
        s_axi_wready  = !w_held_r;
      end
      W_COMMIT: ram_we_s     = aw_in_range_s && !rst;
      W_RESP:   s_axi_bvalid = 1'b1;
      default:  ram_we_s     = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      aw_idx_r  <= 30'd0;
      w_data_r  <= 32'd0;
      w_strb_r  <= 4'd0;
      bresp_r   <= RESP_OKAY;
    end else begin
      if (aw_fire_s) begin
        aw_held_r <= 1'b1;
        aw_idx_r  <= word_index(s_axi_awaddr);
      end else if (w_state_r == W_RESP && s_axi_bready) begin
        aw_held_r <= 1'b0;
      end
      if (w_fire_s) begin
        w_held_r <= 1'b1;
        w_data_r <= s_axi_wdata;
        w_strb_r <= s_axi_wstrb;
      end else if (w_state_r == W_RESP && s_axi_bready) begin
        w_held_r <= 1'b0;
      end
      if (w_state_r == W_COMMIT) begin
        bresp_r <= aw_in_range_s ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign s_axi_bresp = bresp_r;

  // ---------------- read channel and port arbitration ----------------
  assign axi_use_s = (r_state_r == R_MEM) && (!core_req || loss_cnt_r == LIM_C);
  assign core_gnt  = core_req && !((r_state_r == R_MEM) && loss_cnt_r == LIM_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_r <= R_IDLE;
    end else begin
      r_state_r <= r_state_s;
    end
  end

  always_comb begin
    r_state_s = r_state_r;
    case (r_state_r)
      R_IDLE: begin
        if (s_axi_arvalid) r_state_s = R_MEM;
        else               r_state_s = R_IDLE;
      end
      R_MEM: begin
        if (axi_use_s) r_state_s = R_RESP;
        else           r_state_s = R_MEM;
      end
      R_RESP: begin
        if (s_axi_rready) r_state_s = R_IDLE;
        else              r_state_s = R_RESP;
      end
      default: r_state_s = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (r_state_r)
      R_IDLE:  s_axi_arready = 1'b1;
      R_RESP:  s_axi_rvalid  = 1'b1;
      default: s_axi_rvalid  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_idx_r   <= 30'd0;
      loss_cnt_r <= {CNT_W{1'b0}};
      rresp_r    <= RESP_OKAY;
      rd_oor_r   <= 1'b0;
      rd_first_r <= 1'b0;
      rd_hold_r  <= 32'd0;
    end else begin
      rd_first_r <= axi_use_s;
      if (r_state_r == R_IDLE && s_axi_arvalid) begin
        ar_idx_r <= word_index(s_axi_araddr);
      end
      if (axi_use_s) begin
        loss_cnt_r <= {CNT_W{1'b0}};
        rresp_r    <= ar_in_range_s ? RESP_OKAY : RESP_SLVERR;
        rd_oor_r   <= !ar_in_range_s;
      end else if (r_state_r == R_MEM && core_req) begin
        loss_cnt_r <= loss_cnt_r + CNT_W'(1);
      end
      if (rd_first_r) begin
        rd_hold_r <= rd_now_s;
      end
    end
  end

  // The RAM output is valid only in the first R_RESP cycle; later cycles
  // replay the captured copy since core reads keep reusing the port.
  always_comb begin
    if (rd_oor_r) rd_now_s = 32'd0;
    else          rd_now_s = extend_weight(ram_rdata_s);
    if (rd_first_r) s_axi_rdata = rd_now_s;
    else            s_axi_rdata = rd_hold_r;
  end

  assign s_axi_rresp = rresp_r;

  always_comb begin
    if (core_gnt) begin
      ram_re_s    = core_in_range_s;
      ram_raddr_s = core_addr;
    end else begin
      ram_re_s    = axi_use_s && ar_in_range_s;
      ram_raddr_s = ar_idx_r[IDX_W-1:0];
    end
  end

  // ---------------- core read return ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      core_valid_r <= 1'b0;
      core_oor_r   <= 1'b0;
    end else begin
      core_valid_r <= core_gnt;
      core_oor_r   <= !core_in_range_s;
    end
  end

  always_comb begin
    if (core_valid_r && !core_oor_r) core_weight = ram_rdata_s;
    else                             core_weight = {WEIGHT_W{1'b0}};
  end

  assign core_valid = core_valid_r;

  synapse_ram #(
    .DEPTH  (NUM_SYNAPSES),
    .WIDTH  (WEIGHT_W),
    .ADDR_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (aw_idx_r[IDX_W-1:0]),
    .wbe   (w_strb_r[NB-1:0]),
    .wdata (w_data_r[WEIGHT_W-1:0]),
    .re    (ram_re_s),
    .raddr (ram_raddr_s),
    .rdata (ram_rdata_s)
  );

endmodule

// File: tb/tb_synapse_weight_mem.sv
// Randomized self-checking bench: two instances (zero- and sign-extending)
// driven in lockstep and compared against an array-based weight model.
module tb_synapse_weight_mem;

  localparam int NUM   = 100;
  localparam int LIM   = 4;
  localparam int IDX_W = $clog2(NUM);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_awvalid, s_axi_wvalid, s_axi_bready, s_axi_arvalid, s_axi_rready;
  logic        core_req;
  logic [IDX_W-1:0] core_addr;

  logic        awready, wready, bvalid, arready, rvalid, core_gnt, core_valid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [15:0] core_weight;
  logic        awready_x, wready_x, bvalid_x, arready_x, rvalid_x, core_gnt_x, core_valid_x;
  logic [1:0]  bresp_x, rresp_x;
  logic [31:0] rdata_x;
  logic [15:0] core_weight_x;

  synapse_weight_mem #(.NUM_SYNAPSES(NUM), .WEIGHT_W(16), .SIGN_EXT(0), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(s_axi_rready),
    .core_req(core_req), .core_addr(core_addr), .core_gnt(core_gnt),
    .core_valid(core_valid), .core_weight(core_weight)
  );

  synapse_weight_mem #(.NUM_SYNAPSES(NUM), .WEIGHT_W(16), .SIGN_EXT(1), .STARVE_LIM(LIM)) dut_x (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(awready_x),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(wready_x),
    .s_axi_bresp(bresp_x), .s_axi_bvalid(bvalid_x), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(arready_x),
    .s_axi_rdata(rdata_x), .s_axi_rresp(rresp_x), .s_axi_rvalid(rvalid_x), .s_axi_rready(s_axi_rready),
    .core_req(core_req), .core_addr(core_addr), .core_gnt(core_gnt_x),
    .core_valid(core_valid_x), .core_weight(core_weight_x)
  );

  logic [15:0] ref_mem [NUM];
  int n_cmp = 0;
  int n_err = 0;
  int core_mode = 0;            // 0 idle, 1 random, 2 forced request
  logic [IDX_W-1:0] force_addr = '0;
  bit core_chk_en = 1'b0;
  bit pend = 1'b0;
  logic [15:0] pend_w = 16'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rdata(input logic [29:0] idx, input bit sx);
    logic [15:0] w;
    if (idx >= NUM) return 32'h0;
    w = ref_mem[idx];
    return sx ? {{16{w[15]}}, w} : {16'h0, w};
  endfunction

  // Core input driver: changes just after the rising edge.
  initial begin
    core_req = 1'b0; core_addr = '0;
    forever begin
      @(posedge clk); #1;
      case (core_mode)
        1: begin
          core_req  = ($urandom_range(0, 3) != 0);
          core_addr = IDX_W'($urandom_range(0, NUM + 3));
        end
        2: begin core_req = 1'b1; core_addr = force_addr; end
        default: core_req = 1'b0;
      endcase
    end
  end

  // Core return checker: every grant must produce exactly one valid next cycle.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (core_chk_en) begin
        if (pend) begin
          check_eq("core_valid", 32'(core_valid), 32'd1);
          check_eq("core_weight", 32'(core_weight), 32'(pend_w));
          check_eq("core_weight_x", 32'(core_weight_x), 32'(pend_w));
        end else begin
          check_eq("core_valid_idle", 32'(core_valid), 32'd0);
        end
      end
      pend   = core_chk_en && core_gnt;
      pend_w = (core_addr < NUM) ? ref_mem[core_addr] : 16'h0;
    end
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly);
    bit aw_done, w_done, aw_fire, w_fire;
    int cyc, lat, hold;
    logic [29:0] idx;
    aw_done = 0; w_done = 0; cyc = 0;
    idx = addr[31:2];
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge clk);
      s_axi_awaddr  = addr;
      s_axi_awvalid = !aw_done && (cyc >= aw_dly);
      s_axi_wdata   = data;
      s_axi_wstrb   = strb;
      s_axi_wvalid  = !w_done && (cyc >= w_dly);
      #1;
      aw_fire = s_axi_awvalid && awready;
      w_fire  = s_axi_wvalid && wready;
      @(posedge clk);
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done = 1;
      cyc++;
    end
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check_eq("aw_w_accept", 32'({aw_done, w_done}), 32'd3);
    lat = 1;
    while (!bvalid && lat < 20) begin @(negedge clk); lat++; end
    if (aw_dly == 0 && w_dly == 0) check_eq("b_latency", 32'(lat), 32'd3);
    check_eq("bvalid", 32'(bvalid), 32'd1);
    check_eq("bresp", 32'(bresp), (idx < NUM) ? 32'd0 : 32'd2);
    check_eq("bresp_x", 32'(bresp_x), (idx < NUM) ? 32'd0 : 32'd2);
    hold = $urandom_range(0, 2);
    repeat (hold) begin @(negedge clk); check_eq("bvalid_hold", 32'(bvalid), 32'd1); end
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
    #1;
    check_eq("bvalid_clear", 32'(bvalid), 32'd0);
    check_eq("awready_back", 32'({awready, wready}), 32'd3);
    if (idx < NUM) begin
      for (int b = 0; b < 2; b++)
        if (strb[b]) ref_mem[idx][b*8 +: 8] = data[b*8 +: 8];
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, output int losses);
    int cyc, hold;
    bit taken, gnt_exp;
    logic [29:0] idx;
    logic [31:0] e0, e1;
    idx = addr[31:2];
    @(negedge clk);
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    #1;
    check_eq("arready", 32'(arready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    #1;
    losses = 0; taken = 0; cyc = 1;
    // Core wins while it requests and fewer than LIM losses have accrued.
    while (!taken && cyc < 40) begin
      gnt_exp = core_req && (losses < LIM);
      check_eq("core_gnt", 32'(core_gnt), 32'(gnt_exp));
      check_eq("rvalid_wait", 32'(rvalid), 32'd0);
      if (gnt_exp) losses++;
      else taken = 1;
      @(negedge clk); #1;
      cyc++;
    end
    check_eq("r_latency", 32'(cyc), 32'(2 + losses));
    e0 = exp_rdata(idx, 1'b0);
    e1 = exp_rdata(idx, 1'b1);
    check_eq("rvalid", 32'({rvalid, rvalid_x}), 32'd3);
    check_eq("rresp", 32'(rresp), (idx < NUM) ? 32'd0 : 32'd2);
    check_eq("rresp_x", 32'(rresp_x), (idx < NUM) ? 32'd0 : 32'd2);
    check_eq("rdata", rdata, e0);
    check_eq("rdata_x", rdata_x, e1);
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      @(negedge clk); #1;
      check_eq("rvalid_hold", 32'(rvalid), 32'd1);
      check_eq("rdata_hold", rdata, e0);
      check_eq("rdata_x_hold", rdata_x, e1);
    end
    s_axi_rready = 1'b1;
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
    @(negedge clk); #1;
    check_eq("rvalid_clear", 32'(rvalid), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int l;
    logic [15:0] old_w, new_w;
    logic [31:0] a;
    rst = 1'b1;
    s_axi_awaddr = 32'h0; s_axi_awvalid = 1'b0; s_axi_wdata = 32'h0; s_axi_wstrb = 4'h0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = 32'h0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 32'({awready, wready, arready}), 32'd7);
    check_eq("rst_valid", 32'({bvalid, rvalid, core_valid}), 32'd0);
    check_eq("rst_resp", 32'({bresp, rresp}), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_core_weight", 32'(core_weight), 32'd0);
    rst = 1'b0;
    core_chk_en = 1'b1;

    for (int i = 0; i < NUM; i++)
      axi_write(32'(i * 4), $urandom, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2));

    // AW two cycles ahead of W, then read back
    axi_write(32'h10, 32'h0000_BEEF, 4'hF, 0, 2);
    axi_read(32'h10, l);
    check_eq("beef_direct", rdata_x, 32'hFFFF_BEEF);
    // W ahead of AW, low byte only
    axi_write(32'h10, 32'h0000_0012, 4'h1, 2, 0);
    axi_read(32'h10, l);
    // strobes above the weight width have no effect
    axi_write(32'h10, 32'hFFFF_FFFF, 4'hC, 0, 0);
    axi_read(32'h10, l);
    axi_write(32'h14, 32'h0000_8001, 4'hF, 0, 0);
    axi_read(32'h14, l);
    // out-of-range, including an index that aliases 5 when truncated
    axi_write(32'(NUM * 4), 32'h0000_1234, 4'hF, 1, 0);
    axi_write(32'((128 + 5) * 4), 32'h0000_5555, 4'hF, 0, 0);
    axi_read(32'(NUM * 4), l);
    axi_read(32'h14, l);

    // starvation bound with core request held high
    force_addr = IDX_W'(7);
    core_mode = 2;
    axi_read(32'h1C, l);
    check_eq("starve_losses", 32'(l), 32'(LIM));
    repeat (4) @(negedge clk);
    core_mode = 0;
    repeat (2) @(negedge clk);

    // same-cycle core read and AXI commit to index 9 returns old data
    core_chk_en = 1'b0;
    old_w = ref_mem[9];
    new_w = ~old_w;
    @(negedge clk);
    s_axi_awaddr = 32'h24; s_axi_wdata = {16'h0, new_w}; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    force_addr = IDX_W'(9); core_mode = 2;
    @(negedge clk);
    core_mode = 0;
    #1;
    check_eq("rw_collide_gnt", 32'(core_gnt), 32'd1);
    @(negedge clk); #1;
    check_eq("rw_collide_valid", 32'(core_valid), 32'd1);
    check_eq("rw_collide_old", 32'(core_weight), 32'(old_w));
    check_eq("rw_collide_b", 32'({bvalid, bresp}), 32'b100);
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
    ref_mem[9] = new_w;
    core_chk_en = 1'b1;
    axi_read(32'h24, l);

    // reset while the write sits in W_COMMIT
    core_chk_en = 1'b0;
    @(negedge clk);
    s_axi_awaddr = 32'h2C; s_axi_wdata = {16'h0, ~ref_mem[11]}; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("midrst_bvalid", 32'(bvalid), 32'd0);
    check_eq("midrst_ready", 32'({awready, wready, arready}), 32'd7);
    check_eq("midrst_core_valid", 32'(core_valid), 32'd0);
    core_chk_en = 1'b1;
    axi_read(32'h2C, l);
    axi_write(32'h2C, 32'h0000_A5A5, 4'hF, 0, 0);
    axi_read(32'h2C, l);

    // randomized mix of writes (core idle) and reads against core traffic
    for (int it = 0; it < 60; it++) begin
      a = (32'($urandom_range(0, NUM + 3)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        core_mode = 0;
        axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
      end else begin
        core_mode = 1;
        axi_read(a, l);
      end
    end
    core_mode = 0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/synapse_weight_mem.md
SYNAPSE_WEIGHT_MEM -- requirements
Module: synapse_weight_mem

Interface
REQ-001 SHALL have parameter NUM_SYNAPSES, default 72895: weight entries.
REQ-002 SHALL have parameter WEIGHT_W, default 16: weight width; legal 8, 16, 32.
REQ-003 SHALL have parameter SIGN_EXT, default 0: 1 sign-extends AXI read data, 0 zero-extends.
REQ-004 SHALL have parameter STARVE_LIM, default 4: maximum consecutive AXI-read losses to the core port.
REQ-005 clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-006 s_axi_aw{addr,valid,ready}  in/in/out  32/1/1  AXI4-Lite write address; word index = addr[31:2].
REQ-007 s_axi_w{data,strb,valid,ready}  in/in/in/out  32/4/1/1  write data.
REQ-008 s_axi_b{resp,valid,ready}  out/out/in  2/1/1  write response.
REQ-009 s_axi_ar{addr,valid,ready}  in/in/out  32/1/1  read address.
REQ-010 s_axi_r{data,resp,valid,ready}  out/out/out/in  32/2/1/1  read data.
REQ-011 core_req  in  1  spike-engine weight read request.
REQ-012 core_addr  in  $clog2(NUM_SYNAPSES)  synapse index.
REQ-013 core_gnt  out  1  request accepted this cycle (combinational).
REQ-014 core_valid  out  1  core_weight valid.
REQ-015 core_weight  out  WEIGHT_W  weight read data.

Function
REQ-016 Write FSM: W_IDLE, W_COMMIT, W_RESP; read FSM: R_IDLE, R_MEM, R_RESP; both SHALL run independently and concurrently.
REQ-017 In W_IDLE, awready = !aw_held and wready = !w_held; AW and W SHALL be accepted in either order or the same cycle, and each is latched.
REQ-018 When both are held, the FSM SHALL enter W_COMMIT: write once, updating only bytes with strb set and within WEIGHT_W; strb bits above WEIGHT_W/8 ignored.
REQ-019 Out-of-range write (index >= NUM_SYNAPSES) SHALL NOT modify memory and SHALL give bresp=2'b10; in-range gives 2'b00.
REQ-020 W_RESP SHALL hold bvalid until bready, then return to W_IDLE with both holds cleared.
REQ-021 R_IDLE: arready=1; a handshake latches the index and enters R_MEM.
REQ-022 R_MEM SHALL use the shared read port only when core_req=0 or the loss counter equals STARVE_LIM; otherwise it waits and increments the counter.
REQ-023 On read-port use, rdata/rresp SHALL be registered next cycle in R_RESP; in-range: extended weight, 2'b00; out-of-range: 0, 2'b10.
REQ-024 R_RESP SHALL hold rvalid/rdata stable until rready, then go to R_IDLE; loss counter clears when the AXI read uses the port.
REQ-025 core_gnt = core_req && !(R_MEM && counter==STARVE_LIM); core_valid SHALL pulse exactly one cycle after a grant; no core backpressure.
REQ-026 Out-of-range core_addr SHALL return core_weight=0 with core_valid asserted.
REQ-027 Read and write to the same index in the same cycle SHALL return old data.
REQ-028 Throughput: one core read per cycle; AXI write 3 cycles minimum AW/W to bvalid; AXI read 2 cycles minimum AR to rvalid.

Reset
REQ-029 Reset SHALL force W_IDLE, R_IDLE, clear holds and counter, and set awready=wready=arready=1 (combinational from state), bvalid=rvalid=core_valid=0, bresp=rresp=0, rdata=0, core_weight=0.
REQ-030 Reset mid-transaction SHALL abandon it without a response; a pending commit is not written; memory contents are not reset.

Structure
REQ-031 State enums, response codes (OKAY, SLVERR) and the word-index shift SHALL live in package snn_mem_pkg.
REQ-032 Storage SHALL be one sub-module, synapse_ram (1 write port with byte enables, 1 registered read port), inferable as block RAM.

Verification
REQ-033 AW before W (2 cycles apart), addr 0x10, data 0x0000BEEF, strb 0xF -> bresp 00; AXI read 0x10 -> rdata 0x0000BEEF, rresp 00.
REQ-034 W before AW, strb 0x1, data 0x12, to index 4 holding 0xBEEF -> stored 0xBE12.
REQ-035 Write to index NUM_SYNAPSES -> bresp 10, memory unchanged; read same -> rdata 0, rresp 10.
REQ-036 SIGN_EXT=1, weight 0x8001 -> rdata 0xFFFF8001.
REQ-037 core_req held high 10 cycles during AXI read -> AXI wins after exactly STARVE_LIM losses, core_gnt low for that one cycle, core_valid follows each grant by 1 cycle.
REQ-038 rst asserted in W_COMMIT -> no write, bvalid 0, next write transaction completes normally.
